// File: rtl/factorial_ctrl.sv
// rtl/factorial_ctrl.sv - N! sequencer feeding the Booth multiplier three 31-bit limb products per factor
// Optional: FACTORIAL_OVF_EN builds the sticky 64-bit overflow flag; otherwise ovf is tied low.
module factorial_ctrl #(
  parameter int N_W   = 32,
  parameter int ACC_W = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_W-1:0]     n,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   fact,
  output logic               ovf,
  output logic               mul_op_start,
  output logic               mul_op_clear,
  output logic [N_W-1:0]     mul_multiplicand,
  output logic [N_W-1:0]     mul_multiplier,
  input  logic               mul_op_done,
  input  logic [2*N_W-1:0]   mul_result
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    CLR   = 3'd4,
    ACC   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state, state_d;
  logic [N_W-1:0]   n_q;
  logic [N_W-1:0]   k;
  logic [1:0]       j;
  logic [ACC_W-1:0] acc;
  logic [63:0]      p0, p1, p2;
  logic [63:0]      sum_lo;

  // Limbs stay below 2^31 so the signed multiplier always sees positive operands.
  function automatic logic [31:0] limb(input logic [63:0] a, input logic [1:0] idx);
    case (idx)
      2'd0:    limb = {1'b0, a[30:0]};
      2'd1:    limb = {1'b0, a[61:31]};
      default: limb = {30'd0, a[63:62]};
    endcase
  endfunction

`ifdef FACTORIAL_OVF_EN
  logic [127:0] sum;
  logic         ovf_q;
  assign sum    = {64'd0, p0} + ({64'd0, p1} << 31) + ({64'd0, p2} << 62);
  assign sum_lo = sum[63:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_q <= 1'b0;
    else if (state == IDLE && start)
      ovf_q <= n[N_W-1];
    else if (state == ACC && (|sum[127:64]))
      ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  assign sum_lo = p0 + (p1 << 31) + (p2 << 62);
  assign ovf    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d      = state;
    mul_op_start = 1'b0;
    mul_op_clear = 1'b0;
    case (state)
      IDLE:  if (start) state_d = n[N_W-1] ? DONE : INIT;
      INIT:  state_d = (k > n_q) ? DONE : ISSUE;
      ISSUE: begin
        mul_op_start = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        mul_op_start = 1'b1;
        if (mul_op_done) state_d = CLR;
      end
      CLR: begin
        mul_op_clear = 1'b1;
        state_d      = (j < 2'd2) ? ISSUE : ACC;
      end
      ACC:     state_d = (k == n_q) ? DONE : INIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      fact             <= 64'd1;
      n_q              <= '0;
      k                <= '0;
      j                <= 2'd0;
      acc              <= 64'd1;
      p0               <= '0;
      p1               <= '0;
      p2               <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          n_q  <= n;
          k    <= 32'd2;
          acc  <= n[N_W-1] ? 64'd0 : 64'd1;
        end
        INIT: if (k <= n_q) begin
          j                <= 2'd0;
          mul_multiplicand <= limb(acc, 2'd0);
          mul_multiplier   <= k;
        end
        WAIT: if (mul_op_done) begin
          case (j)
            2'd0:    p0 <= mul_result;
            2'd1:    p1 <= mul_result;
            default: p2 <= mul_result;
          endcase
        end
        CLR: if (j < 2'd2) begin
          j                <= j + 2'd1;
          mul_multiplicand <= limb(acc, j + 2'd1);
        end
        ACC: begin
          acc <= sum_lo;
          if (k != n_q) k <= k + 32'd1;
        end
        DONE: begin
          fact <= acc;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_ctrl.sv
// tb/tb_factorial_ctrl.sv - scoreboard bench for factorial_ctrl with a behavioural Booth multiplier
module tb_factorial_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] n_in = 32'd0;
  logic        busy, done, ovf, mul_op_start, mul_op_clear;
  logic [63:0] fact;
  logic [31:0] mul_multiplicand, mul_multiplier;
  logic        mdone, spur;
  logic [63:0] mres;
  logic [1:0]  mcnt;

  always #5 clk = ~clk;

  factorial_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n(n_in),
    .busy(busy), .done(done), .fact(fact), .ovf(ovf),
    .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_op_done(mdone | spur), .mul_result(mres)
  );

`ifdef FACTORIAL_OVF_EN
  localparam logic OVF_BIG = 1'b1;
`else
  localparam logic OVF_BIG = 1'b0;
`endif

  // Multiplier model: done three cycles after request, held until clear.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdone <= 1'b0; mcnt <= 2'd0; mres <= 64'd0;
    end else if (mul_op_clear) begin
      mdone <= 1'b0; mcnt <= 2'd0;
    end else if (mul_op_start && !mdone) begin
      if (mcnt == 2'd2) begin
        mdone <= 1'b1;
        mres  <= {{32{mul_multiplicand[31]}}, mul_multiplicand} * {{32{mul_multiplier[31]}}, mul_multiplier};
      end else begin
        mcnt <= mcnt + 2'd1;
      end
    end
  end

  typedef struct { logic [63:0] f; logic o; } exp_t;
  exp_t exp_q[$];
  int tests = 0, failed = 0;
  int starts = 0, clears = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  logic start_prev = 1'b0, clr_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      start_prev  = 1'b0;
      clr_pending = 1'b0;
    end else begin
      if (mul_op_start && !start_prev) begin
        starts++;
        chk("clear_between_starts", {63'd0, clr_pending}, 64'd0);
        clr_pending = 1'b1;
      end
      if (mul_op_clear) begin
        clears++;
        clr_pending = 1'b0;
      end
      start_prev = mul_op_start;
      if (done) begin
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fact", fact, e.f);
          chk("ovf", {63'd0, ovf}, {63'd0, e.o});
          chk("busy_at_done", {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] nv, input logic [63:0] ef, input logic eo,
                         input int est, input int max_lat, input int extra_at);
    exp_t e;
    @(posedge clk);
    starts = 0;
    clears = 0;
    @(negedge clk);
    e.f = ef; e.o = eo;
    exp_q.push_back(e);
    n_in = nv; start = 1'b1; start_cyc = cyc + 1;
    for (int c = 0; c < 4000 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (c == extra_at) begin start = 1'b1; n_in = 32'd7; end
      else start = 1'b0;
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("op_start_count", 64'(starts), 64'(est));
    chk("op_clear_count", 64'(clears), 64'(est));
    if (max_lat > 0) chk("done_latency_ok", {63'd0, (done_cyc - start_cyc) <= max_lat}, 64'd1);
  endtask

  initial begin
    spur = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_fact", fact, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_op_start", {63'd0, mul_op_start}, 64'd0);

    run_job(32'd0, 64'd1, 1'b0, 0, 3, -1);
    run_job(32'd1, 64'd1, 1'b0, 0, 3, -1);
    spur = 1'b1; @(negedge clk); spur = 1'b0;
    chk("spurious_done_ignored", {63'd0, busy | mul_op_start}, 64'd0);
    run_job(32'd5, 64'd120, 1'b0, 12, 0, -1);
    run_job(32'd20, 64'h21C3677C82B40000, 1'b0, 57, 0, -1);
    run_job(32'd21, 64'hC5077D36B8C40000, OVF_BIG, 60, 0, -1);
    run_job(32'h8000_0000, 64'd0, OVF_BIG, 0, 3, -1);
    run_job(32'd2, 64'd2, 1'b0, 3, 0, -1);

    // Reset while the controller waits on the multiplier.
    @(negedge clk);
    starts = 0;
    n_in = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int c;
      c = 0;
      while (c < 2000 && !(starts >= 5 && mul_op_start && !mdone)) begin
        @(negedge clk);
        c++;
      end
      if (c >= 2000) chk("wait_state_timeout", 64'd1, 64'd0);
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_fact", fact, 64'd1);
    chk("midrst_ovf", {63'd0, ovf}, 64'd0);
    chk("midrst_op_start", {63'd0, mul_op_start}, 64'd0);
    chk("midrst_op_clear", {63'd0, mul_op_clear}, 64'd0);
    chk("midrst_operands", {mul_multiplicand, mul_multiplier}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_job(32'd3, 64'd6, 1'b0, 6, 0, 2);
    repeat (20) @(negedge clk);
    chk("idle_after_jobs", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
